// File: rtl/fp_arith_unit.sv
// fp_arith_unit: IEEE-754 binary32 add / subtract / multiply / divide.
//
// Add, subtract and multiply are computed combinationally from the live
// operands and registered on the accepting edge, giving a one-cycle latency.
// Divide is a 25-iteration restoring divider, with its result issued 26
// cycles after acceptance.
// Number format: denormals are flushed to signed zero on input and output,
// rounding is toward zero, and every NaN result is 0x7FC00000.
//
// Build option: define FP_DIV_EN to include the divider. Without it, opcode 3
// returns 0x7FC00000 after one cycle and s_axis_tready is tied high.
//
// Ports:
//   aclk, areset                   clock, synchronous active-high reset
//   s_axis_a_*/s_axis_b_*          operands (valid + binary32 data)
//   s_axis_operation_*             opcode (valid + 8-bit data, bits [1:0] used)
//   s_axis_tready                  unit can accept an operation
//   m_axis_result_tvalid/tdata     one-cycle result pulse / held result
module fp_arith_unit (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_operation_tvalid,
  input  logic [7:0]  s_axis_operation_tdata,
  output logic        s_axis_tready,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic [1:0]  w_op;
  logic        w_accept;

  assign w_op     = s_axis_operation_tdata[1:0];
  assign w_accept = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid & s_axis_tready;

  // Operand unpack; a zero exponent field (zero or denormal) reads as zero.
  logic        w_sa, w_sb, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  assign w_sa     = s_axis_a_tdata[31];
  assign w_sb     = s_axis_b_tdata[31];
  assign w_ea     = s_axis_a_tdata[30:23];
  assign w_eb     = s_axis_b_tdata[30:23];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (s_axis_a_tdata[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (s_axis_b_tdata[22:0] == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (s_axis_a_tdata[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (s_axis_b_tdata[22:0] != 23'd0);
  assign w_ma     = w_a_zero ? 24'd0 : {1'b1, s_axis_a_tdata[22:0]};
  assign w_mb     = w_b_zero ? 24'd0 : {1'b1, s_axis_b_tdata[22:0]};

  // Add / subtract: align the smaller operand into a 27-bit field
  // (significand + guard/round/sticky), add or subtract, then normalize.
  logic              w_sb_eff, w_swap, w_s_big, w_s_small, w_eff_sub, w_lost;
  logic [7:0]        w_e_big, w_e_small, w_e_diff;
  logic [23:0]       w_m_big, w_m_small;
  logic [26:0]       w_small_sh, w_norm;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic signed [9:0] w_add_exp;
  logic [31:0]       w_add_res;

  always_comb begin
    w_sb_eff  = w_sb ^ (w_op == 2'd1);
    w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
    w_s_big   = w_swap ? w_sb_eff : w_sa;
    w_s_small = w_swap ? w_sa : w_sb_eff;
    w_e_big   = w_swap ? w_eb : w_ea;
    w_e_small = w_swap ? w_ea : w_eb;
    w_m_big   = w_swap ? w_mb : w_ma;
    w_m_small = w_swap ? w_ma : w_mb;
    w_e_diff  = w_e_big - w_e_small;
    w_lost    = 1'b0;
    if (w_e_diff > 8'd26) begin
      w_small_sh = {26'd0, |w_m_small};
    end else begin
      w_small_sh    = {w_m_small, 3'b000} >> w_e_diff;
      w_lost        = |({w_m_small, 3'b000} & ((27'd1 << w_e_diff) - 27'd1));
      w_small_sh[0] = w_small_sh[0] | w_lost;
    end
    w_eff_sub = w_s_big ^ w_s_small;
    if (w_eff_sub) w_sum = {1'b0, w_m_big, 3'b000} - {1'b0, w_small_sh};
    else           w_sum = {1'b0, w_m_big, 3'b000} + {1'b0, w_small_sh};
    w_lz = 5'd0;
    if (w_sum[27]) begin
      w_norm    = w_sum[27:1] | {26'd0, w_sum[0]};
      w_add_exp = 10'(w_e_big) + 10'sd1;
    end else begin
      // Ascending scan: the last hit is the most significant set bit.
      for (int i = 0; i < 27; i++) begin
        if (w_sum[i]) w_lz = 5'(26 - i);
      end
      w_norm    = w_sum[26:0] << w_lz;
      w_add_exp = 10'(w_e_big) - 10'(w_lz);
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa ^ w_sb_eff)))
      w_add_res = QNAN;
    else if (w_a_inf)              w_add_res = {w_sa, 8'hFF, 23'd0};
    else if (w_b_inf)              w_add_res = {w_sb_eff, 8'hFF, 23'd0};
    else if (w_a_zero && w_b_zero) w_add_res = {w_sa & w_sb_eff, 31'd0};
    else if (w_sum == 28'd0)       w_add_res = 32'd0;
    else if (w_add_exp >= 10'sd255) w_add_res = {w_s_big, 8'hFF, 23'd0};
    else if (w_add_exp <= 10'sd0)   w_add_res = {w_s_big, 31'd0};
    else                           w_add_res = {w_s_big, w_add_exp[7:0], w_norm[25:3]};
  end

  // Multiply: 24x24 -> 48-bit product; the product lies in [2^46, 2^48).
  logic [47:0]       w_prod;
  logic signed [9:0] w_mul_exp;
  logic [22:0]       w_mul_frac;
  logic              w_s_mul;
  logic [31:0]       w_mul_res;

  always_comb begin
    w_s_mul = w_sa ^ w_sb;
    w_prod  = w_ma * w_mb;
    if (w_prod[47]) begin
      w_mul_frac = w_prod[46:24];
      w_mul_exp  = 10'(w_ea) + 10'(w_eb) - 10'sd126;
    end else begin
      w_mul_frac = w_prod[45:23];
      w_mul_exp  = 10'(w_ea) + 10'(w_eb) - 10'sd127;
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_mul_res = QNAN;
    else if (w_a_inf || w_b_inf)    w_mul_res = {w_s_mul, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)  w_mul_res = {w_s_mul, 31'd0};
    else if (w_mul_exp >= 10'sd255) w_mul_res = {w_s_mul, 8'hFF, 23'd0};
    else if (w_mul_exp <= 10'sd0)   w_mul_res = {w_s_mul, 31'd0};
    else                            w_mul_res = {w_s_mul, w_mul_exp[7:0], w_mul_frac};
  end

  logic [31:0] w_fast_res;
  always_comb begin
    case (w_op)
      2'd0, 2'd1: w_fast_res = w_add_res;
      2'd2:       w_fast_res = w_mul_res;
      default:    w_fast_res = QNAN;
    endcase
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{s_axis_operation_tdata[7:2], w_norm[26], w_norm[2:0], w_prod[22:0]};

`ifdef FP_DIV_EN
  typedef enum logic {S_IDLE, S_DIV_BUSY} state_t;
  state_t            r_state;
  logic [25:0]       r_rem;
  logic [23:0]       r_div_mb;
  logic [24:0]       r_quo;
  logic [4:0]        r_cnt;
  logic              r_div_sign, r_div_special;
  logic signed [9:0] r_div_exp;
  logic [31:0]       r_div_special_res;

  // Specials are resolved at acceptance; the divider still runs its full length.
  logic        w_div_special;
  logic [31:0] w_div_special_res;
  always_comb begin
    w_div_special     = 1'b1;
    w_div_special_res = QNAN;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_div_special_res = QNAN;
    else if (w_a_inf || w_b_zero) w_div_special_res = {w_sa ^ w_sb, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_inf) w_div_special_res = {w_sa ^ w_sb, 31'd0};
    else                          w_div_special = 1'b0;
  end

  // Quotient = floor(ma * 2^24 / mb); bit 24 set means the ratio was >= 1.
  logic signed [9:0] w_div_exp;
  logic [22:0]       w_div_frac;
  logic [31:0]       w_div_res;
  always_comb begin
    w_div_exp  = r_quo[24] ? r_div_exp : r_div_exp - 10'sd1;
    w_div_frac = r_quo[24] ? r_quo[23:1] : r_quo[22:0];
    if (w_div_exp >= 10'sd255)   w_div_res = {r_div_sign, 8'hFF, 23'd0};
    else if (w_div_exp <= 10'sd0) w_div_res = {r_div_sign, 31'd0};
    else                          w_div_res = {r_div_sign, w_div_exp[7:0], w_div_frac};
  end

  assign s_axis_tready = (r_state == S_IDLE);
`else
  assign s_axis_tready = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
`ifdef FP_DIV_EN
      r_state           <= S_IDLE;
      r_rem             <= '0;
      r_div_mb          <= '0;
      r_quo             <= '0;
      r_cnt             <= '0;
      r_div_sign        <= 1'b0;
      r_div_special     <= 1'b0;
      r_div_exp         <= '0;
      r_div_special_res <= '0;
`endif
    end else begin
      r_tvalid <= 1'b0;
`ifdef FP_DIV_EN
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == 2'd3) begin
              r_state           <= S_DIV_BUSY;
              r_rem             <= {2'b00, w_ma};
              r_div_mb          <= w_mb;
              r_quo             <= '0;
              r_cnt             <= 5'd25;
              r_div_sign        <= w_sa ^ w_sb;
              r_div_exp         <= 10'(w_ea) - 10'(w_eb) + 10'sd127;
              r_div_special     <= w_div_special;
              r_div_special_res <= w_div_special_res;
            end else begin
              r_tvalid <= 1'b1;
              r_tdata  <= w_fast_res;
            end
          end
        end
        S_DIV_BUSY: begin
          if (r_cnt != 5'd0) begin
            if (r_rem >= {2'b00, r_div_mb}) begin
              r_rem <= (r_rem - {2'b00, r_div_mb}) << 1;
              r_quo <= {r_quo[23:0], 1'b1};
            end else begin
              r_rem <= r_rem << 1;
              r_quo <= {r_quo[23:0], 1'b0};
            end
            r_cnt <= r_cnt - 5'd1;
          end else begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_div_special ? r_div_special_res : w_div_res;
            r_state  <= S_IDLE;
          end
        end
      endcase
`else
      if (w_accept) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_fast_res;
      end
`endif
    end
  end

  assign m_axis_result_tvalid = r_tvalid;
  assign m_axis_result_tdata  = r_tdata;
endmodule

// File: tb/tb_fp_arith_unit.sv
module tb_fp_arith_unit;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_axis_a_tvalid = 1'b0;
  logic [31:0] s_axis_a_tdata = '0;
  logic        s_axis_b_tvalid = 1'b0;
  logic [31:0] s_axis_b_tdata = '0;
  logic        s_axis_operation_tvalid = 1'b0;
  logic [7:0]  s_axis_operation_tdata = '0;
  logic        s_axis_tready;
  logic        m_axis_result_tvalid;
  logic [31:0] m_axis_result_tdata;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  int n_tests = 0;
  int n_fail = 0;
  int n_tready_low = 0;

  fp_arith_unit dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .s_axis_a_tvalid         (s_axis_a_tvalid),
    .s_axis_a_tdata          (s_axis_a_tdata),
    .s_axis_b_tvalid         (s_axis_b_tvalid),
    .s_axis_b_tdata          (s_axis_b_tdata),
    .s_axis_operation_tvalid (s_axis_operation_tvalid),
    .s_axis_operation_tdata  (s_axis_operation_tdata),
    .s_axis_tready           (s_axis_tready),
    .m_axis_result_tvalid    (m_axis_result_tvalid),
    .m_axis_result_tdata     (m_axis_result_tdata)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (!areset && !s_axis_tready) n_tready_low++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    s_axis_a_tdata = a;
    s_axis_b_tdata = b;
    s_axis_operation_tdata = op;
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    s_axis_operation_tvalid = 1'b1;
  endtask

  task automatic idle();
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    s_axis_operation_tvalid = 1'b0;
  endtask

  // One-cycle operation: result must be valid right after the accepting edge.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] op, input logic [31:0] exp);
    @(negedge aclk);
    drive(a, b, op);
    @(posedge aclk);
    #1;
    idle();
    check({tag, "_tvalid"}, 32'(m_axis_result_tvalid), 32'd1);
    check(tag, m_axis_result_tdata, exp);
  endtask

  // Divide with bounded wait; latency counted in edges after acceptance.
  task automatic div_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    lat = 0;
    @(negedge aclk);
    drive(a, b, 8'd3);
    @(posedge aclk);
    #1;
    idle();
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge aclk);
      #1;
      if (m_axis_result_tvalid) lat = k;
    end
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check(tag, m_axis_result_tdata, exp);
  endtask

  initial begin
    int pulses;

    repeat (2) @(posedge aclk);
    #1;
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_tvalid", 32'(m_axis_result_tvalid), 32'd0);
    check("rst_tdata", m_axis_result_tdata, 32'h0000_0000);
    @(negedge aclk);
    areset = 1'b0;

    single("add_1p2", 32'h3F80_0000, 32'h4000_0000, 8'd0, 32'h4040_0000);
    @(posedge aclk);
    #1;
    check("add_pulse_1cyc", 32'(m_axis_result_tvalid), 32'd0);
    check("add_hold", m_axis_result_tdata, 32'h4040_0000);

    // Back-to-back subtract then multiply.
    @(negedge aclk);
    drive(32'h4040_0000, 32'h3F80_0000, 8'd1);
    @(posedge aclk);
    #1;
    check("b2b_sub_tvalid", 32'(m_axis_result_tvalid), 32'd1);
    check("b2b_sub", m_axis_result_tdata, 32'h4000_0000);
    drive(32'h3FC0_0000, 32'h4000_0000, 8'd2);
    @(posedge aclk);
    #1;
    idle();
    check("b2b_mul_tvalid", 32'(m_axis_result_tvalid), 32'd1);
    check("b2b_mul", m_axis_result_tdata, 32'h4040_0000);

    single("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 8'd1, QNAN);
    single("negz_plus_negz", 32'h8000_0000, 32'h8000_0000, 8'd0, 32'h8000_0000);
    single("mul_overflow", 32'h7F7F_FFFF, 32'h4000_0000, 8'd2, 32'h7F80_0000);
    single("exact_zero_sum", 32'h3F80_0000, 32'hBF80_0000, 8'd0, 32'h0000_0000);
    single("sub_swap_neg", 32'h3F80_0000, 32'h4040_0000, 8'd1, 32'hC000_0000);
    single("mul_neg", 32'h4000_0000, 32'hC040_0000, 8'd2, 32'hC0C0_0000);
    single("nan_in_add", 32'h7F80_0001, 32'h3F80_0000, 8'd0, QNAN);
    single("zero_times_inf", 32'h0000_0000, 32'hFF80_0000, 8'd2, QNAN);
    single("inf_plus_fin", 32'h3F80_0000, 32'hFF80_0000, 8'd0, 32'hFF80_0000);
    single("denorm_flush_add", 32'h8000_0001, 32'h8000_0000, 8'd0, 32'h8000_0000);
    single("mul_underflow", 32'h0080_0000, 32'h0080_0000, 8'd2, 32'h0000_0000);

`ifdef FP_DIV_EN
    // 1/3 with busy-window checks and an add presented while busy.
    @(negedge aclk);
    drive(32'h3F80_0000, 32'h4040_0000, 8'd3);
    @(posedge aclk);
    #1;
    idle();
    for (int k = 1; k <= 26; k++) begin
      @(posedge aclk);
      #1;
      if (k == 3) drive(32'h3F80_0000, 32'h4000_0000, 8'd0);
      if (k == 6) idle();
      if (k < 26) begin
        check("div_busy_tvalid", 32'(m_axis_result_tvalid), 32'd0);
        check("div_busy_tready", 32'(s_axis_tready), 32'd0);
      end else begin
        check("div_done_tvalid", 32'(m_axis_result_tvalid), 32'd1);
        check("div_done_tready", 32'(s_axis_tready), 32'd1);
        check("div_1_3", m_axis_result_tdata, 32'h3EAA_AAAA);
      end
    end
    @(posedge aclk);
    #1;
    check("div_no_stray", 32'(m_axis_result_tvalid), 32'd0);

    div_op("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    div_op("div_6_2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    div_op("div_0_0", 32'h0000_0000, 32'h8000_0000, QNAN);

    // Reset mid-divide.
    @(negedge aclk);
    drive(32'h3F80_0000, 32'h4040_0000, 8'd3);
    @(posedge aclk);
    #1;
    idle();
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_mid_tready", 32'(s_axis_tready), 32'd1);
    check("rst_mid_tdata", m_axis_result_tdata, 32'h0000_0000);
    check("rst_mid_tvalid", 32'(m_axis_result_tvalid), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge aclk);
      #1;
      if (m_axis_result_tvalid) pulses++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 32'd0);
`else
    single("div_disabled", 32'h3F80_0000, 32'h4040_0000, 8'd3, QNAN);
    check("div_dis_tready", 32'(s_axis_tready), 32'd1);
    single("div_disabled_b0", 32'h3F80_0000, 32'h0000_0000, 8'd3, QNAN);
    @(posedge aclk);
    #1;
    check("div_dis_pulse_1cyc", 32'(m_axis_result_tvalid), 32'd0);
    check("tready_never_low", 32'(n_tready_low), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
